// File: rtl/universal_counter_reg.sv
// ---------------------------------------------------------------------------
// universal_counter_reg
//   State-holding stage of a universal counter slice. Four modes: hold,
//   count up (gated by cin), count down (every edge) and parallel load.
//   The combinational cout lets slices be chained into wider counters.
//
// Ports
//   clk       in   rising-edge clock
//   rst       in   synchronous active-high reset (clears q, wrap, ld_ack)
//   mode      in   2'b00 hold, 2'b01 up, 2'b10 down, 2'b11 load
//   cin       in   count enable / carry into bit 0, used in up mode only
//   pin       in   parallel load data
//   clr_wrap  in   clears the sticky wrap flag (a same-cycle wrap wins)
//   q         out  registered count
//   cout      out  combinational carry (up) or borrow (down) for cascading
//   wrap      out  sticky flag: counter wrapped since the last clear
//   ld_ack    out  one-cycle pulse following each load edge
// ---------------------------------------------------------------------------
module universal_counter_reg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic             cin,
  input  logic [WIDTH-1:0] pin,
  input  logic             clr_wrap,
  output logic [WIDTH-1:0] q,
  output logic             cout,
  output logic             wrap,
  output logic             ld_ack
);

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_UP   = 2'b01;
  localparam logic [1:0] MODE_DOWN = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] r_q;
  logic             r_wrap;
  logic             r_ld_ack;

  logic [WIDTH-1:0] w_next_q;
  logic             w_wrap_evt;
  logic             w_cout;
  logic             w_all_ones;
  logic             w_zero;

  assign w_all_ones = &r_q;
  assign w_zero     = ~|r_q;

  // Next-state and cascade output. The carry out of up mode is the AND-chain
  // carry, so a chained upper slice advances exactly when this slice rolls
  // over; the borrow in down mode is only a flag for the upstream sequencer.
  always_comb begin
    w_next_q   = r_q;
    w_wrap_evt = 1'b0;
    w_cout     = 1'b0;
    unique case (mode)
      MODE_HOLD: begin
        w_next_q = r_q;
      end
      MODE_UP: begin
        w_cout = cin & w_all_ones;
        if (cin) begin
          w_next_q   = r_q + ONE;
          w_wrap_evt = w_all_ones;
        end
      end
      MODE_DOWN: begin
        w_cout     = w_zero;
        w_next_q   = r_q - ONE;
        w_wrap_evt = w_zero;
      end
      MODE_LOAD: begin
        w_next_q = pin;
      end
      default: begin
        w_next_q = r_q;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q      <= '0;
      r_wrap   <= 1'b0;
      r_ld_ack <= 1'b0;
    end else begin
      r_q      <= w_next_q;
      r_ld_ack <= (mode == MODE_LOAD);
      // A wrap event in the same cycle as a clear request keeps the flag set,
      // so no wrap can ever be lost to a late clear.
      if (w_wrap_evt) begin
        r_wrap <= 1'b1;
      end else if (clr_wrap) begin
        r_wrap <= 1'b0;
      end
    end
  end

  assign q      = r_q;
  assign cout   = w_cout;
  assign wrap   = r_wrap;
  assign ld_ack = r_ld_ack;

endmodule

// File: tb/tb_universal_counter_reg.sv
module tb_universal_counter_reg;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Main 4-bit device
  logic       rst = 1'b1;
  logic [1:0] mode = 2'b00;
  logic       cin = 1'b0;
  logic [3:0] pin = 4'h0;
  logic       clr_wrap = 1'b0;
  logic [3:0] q;
  logic       cout, wrap, ld_ack;

  universal_counter_reg #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .mode(mode), .cin(cin), .pin(pin),
    .clr_wrap(clr_wrap), .q(q), .cout(cout), .wrap(wrap), .ld_ack(ld_ack)
  );

  // Two cascaded 4-bit slices
  logic       c_rst = 1'b1;
  logic [1:0] c_mode = 2'b00;
  logic       c_cin = 1'b0;
  logic [3:0] lo_q, hi_q;
  logic       lo_cout, hi_cout, lo_wrap, hi_wrap, lo_ld, hi_ld;

  universal_counter_reg #(.WIDTH(4)) u_lo (
    .clk(clk), .rst(c_rst), .mode(c_mode), .cin(c_cin), .pin(4'h0),
    .clr_wrap(1'b0), .q(lo_q), .cout(lo_cout), .wrap(lo_wrap), .ld_ack(lo_ld)
  );
  universal_counter_reg #(.WIDTH(4)) u_hi (
    .clk(clk), .rst(c_rst), .mode(c_mode), .cin(lo_cout), .pin(4'h0),
    .clr_wrap(1'b0), .q(hi_q), .cout(hi_cout), .wrap(hi_wrap), .ld_ack(hi_ld)
  );

  // 1-bit device
  logic       b_rst = 1'b1;
  logic [1:0] b_mode = 2'b00;
  logic       b_cin = 1'b0;
  logic [0:0] b_q;
  logic       b_cout, b_wrap, b_ld;

  universal_counter_reg #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst(b_rst), .mode(b_mode), .cin(b_cin), .pin(1'b0),
    .clr_wrap(1'b0), .q(b_q), .cout(b_cout), .wrap(b_wrap), .ld_ack(b_ld)
  );

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    mode = 2'b01; cin = 1'b1; rst = 1'b1;
    tick(); tick();
    checks++; if (q !== 4'h0) begin errors++; $display("FAIL reset_q: got %0h expected 0", q); end
    checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL reset_wrap: got %0b expected 0", wrap); end
    checks++; if (ld_ack !== 1'b0) begin errors++; $display("FAIL reset_ld_ack: got %0b expected 0", ld_ack); end
    checks++; if (cout !== 1'b0) begin errors++; $display("FAIL reset_cout: got %0b expected 0", cout); end
    rst = 1'b0;
    tick();
    checks++; if (q !== 4'h1) begin errors++; $display("FAIL reset_release_q: got %0h expected 1", q); end
  endtask

  task automatic test_up_wrap();
    mode = 2'b11; pin = 4'hE; cin = 1'b0;
    tick();
    checks++; if (q !== 4'hE) begin errors++; $display("FAIL up_load_q: got %0h expected e", q); end
    checks++; if (ld_ack !== 1'b1) begin errors++; $display("FAIL up_ld_ack: got %0b expected 1", ld_ack); end
    mode = 2'b01; cin = 1'b1;
    #1;
    checks++; if (cout !== 1'b0) begin errors++; $display("FAIL up_cout_e: got %0b expected 0", cout); end
    tick();
    checks++; if (q !== 4'hF) begin errors++; $display("FAIL up_q_f: got %0h expected f", q); end
    checks++; if (ld_ack !== 1'b0) begin errors++; $display("FAIL up_ld_ack_drop: got %0b expected 0", ld_ack); end
    checks++; if (cout !== 1'b1) begin errors++; $display("FAIL up_cout_f: got %0b expected 1", cout); end
    checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL up_wrap_pre: got %0b expected 0", wrap); end
    tick();
    checks++; if (q !== 4'h0) begin errors++; $display("FAIL up_q_0: got %0h expected 0", q); end
    checks++; if (wrap !== 1'b1) begin errors++; $display("FAIL up_wrap_set: got %0b expected 1", wrap); end
    checks++; if (cout !== 1'b0) begin errors++; $display("FAIL up_cout_0: got %0b expected 0", cout); end
    cin = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (q !== 4'h0) begin errors++; $display("FAIL up_cin0_hold: got %0h expected 0", q); end
    end
    checks++; if (wrap !== 1'b1) begin errors++; $display("FAIL up_wrap_sticky: got %0b expected 1", wrap); end
  endtask

  task automatic test_down_wrap();
    mode = 2'b11; pin = 4'h1; clr_wrap = 1'b1;
    tick();
    clr_wrap = 1'b0;
    checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL dn_wrap_clr: got %0b expected 0", wrap); end
    mode = 2'b10; cin = 1'b0;
    #1;
    checks++; if (cout !== 1'b0) begin errors++; $display("FAIL dn_cout_1: got %0b expected 0", cout); end
    tick();
    checks++; if (q !== 4'h0) begin errors++; $display("FAIL dn_q_0: got %0h expected 0", q); end
    checks++; if (cout !== 1'b1) begin errors++; $display("FAIL dn_cout_0: got %0b expected 1", cout); end
    checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL dn_wrap_pre: got %0b expected 0", wrap); end
    tick();
    checks++; if (q !== 4'hF) begin errors++; $display("FAIL dn_q_f: got %0h expected f", q); end
    checks++; if (wrap !== 1'b1) begin errors++; $display("FAIL dn_wrap_set: got %0b expected 1", wrap); end
    checks++; if (cout !== 1'b0) begin errors++; $display("FAIL dn_cout_f: got %0b expected 0", cout); end
    tick();
    checks++; if (q !== 4'hE) begin errors++; $display("FAIL dn_q_e: got %0h expected e", q); end
  endtask

  task automatic test_set_clear();
    mode = 2'b11; pin = 4'hF; clr_wrap = 1'b1;
    tick();
    checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL sc_wrap_clr: got %0b expected 0", wrap); end
    mode = 2'b01; cin = 1'b1; clr_wrap = 1'b1;
    tick();
    checks++; if (q !== 4'h0) begin errors++; $display("FAIL sc_q: got %0h expected 0", q); end
    checks++; if (wrap !== 1'b1) begin errors++; $display("FAIL sc_set_wins: got %0b expected 1", wrap); end
    cin = 1'b0;
    tick();
    clr_wrap = 1'b0;
    checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL sc_clear: got %0b expected 0", wrap); end
  endtask

  task automatic test_hold_priority();
    mode = 2'b11; pin = 4'h7;
    tick();
    mode = 2'b00; cin = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (q !== 4'h7) begin errors++; $display("FAIL hold_q: got %0h expected 7", q); end
      checks++; if (cout !== 1'b0) begin errors++; $display("FAIL hold_cout: got %0b expected 0", cout); end
    end
    checks++; if (ld_ack !== 1'b0) begin errors++; $display("FAIL hold_ld_ack: got %0b expected 0", ld_ack); end
    mode = 2'b11; pin = 4'hA; rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (q !== 4'h0) begin errors++; $display("FAIL prio_q: got %0h expected 0", q); end
    checks++; if (ld_ack !== 1'b0) begin errors++; $display("FAIL prio_ld_ack: got %0b expected 0", ld_ack); end
  endtask

  task automatic test_back_to_back();
    mode = 2'b11; pin = 4'h3;
    tick();
    checks++; if (ld_ack !== 1'b1) begin errors++; $display("FAIL b2b_ack1: got %0b expected 1", ld_ack); end
    pin = 4'h5;
    tick();
    checks++; if (ld_ack !== 1'b1) begin errors++; $display("FAIL b2b_ack2: got %0b expected 1", ld_ack); end
    checks++; if (q !== 4'h5) begin errors++; $display("FAIL b2b_q: got %0h expected 5", q); end
    mode = 2'b00;
    tick();
    checks++; if (ld_ack !== 1'b0) begin errors++; $display("FAIL b2b_ack_end: got %0b expected 0", ld_ack); end
  endtask

  task automatic test_cascade();
    logic [7:0] exp_v;
    c_rst = 1'b1;
    tick();
    c_rst = 1'b0; c_mode = 2'b01; c_cin = 1'b1;
    exp_v = 8'h00;
    #1;
    for (int i = 0; i < 256; i++) begin
      checks++; if ({hi_q, lo_q} !== exp_v) begin errors++; $display("FAIL cas_value: got %0h expected %0h", {hi_q, lo_q}, exp_v); end
      checks++; if (hi_cout !== (exp_v == 8'hFF)) begin errors++; $display("FAIL cas_hi_cout at %0h: got %0b expected %0b", exp_v, hi_cout, (exp_v == 8'hFF)); end
      tick();
      exp_v = exp_v + 8'h01;
    end
    checks++; if ({hi_q, lo_q} !== 8'h00) begin errors++; $display("FAIL cas_final: got %0h expected 0", {hi_q, lo_q}); end
    checks++; if (lo_wrap !== 1'b1) begin errors++; $display("FAIL cas_lo_wrap: got %0b expected 1", lo_wrap); end
    checks++; if (hi_wrap !== 1'b1) begin errors++; $display("FAIL cas_hi_wrap: got %0b expected 1", hi_wrap); end
  endtask

  task automatic test_width1();
    b_rst = 1'b1;
    tick();
    b_rst = 1'b0; b_mode = 2'b01; b_cin = 1'b1;
    tick();
    checks++; if (b_q !== 1'b1) begin errors++; $display("FAIL w1_up1: got %0b expected 1", b_q); end
    checks++; if (b_cout !== 1'b1) begin errors++; $display("FAIL w1_cout: got %0b expected 1", b_cout); end
    tick();
    checks++; if (b_q !== 1'b0) begin errors++; $display("FAIL w1_up0: got %0b expected 0", b_q); end
    checks++; if (b_wrap !== 1'b1) begin errors++; $display("FAIL w1_wrap: got %0b expected 1", b_wrap); end
    b_cin = 1'b0;
    tick();
    checks++; if (b_q !== 1'b0) begin errors++; $display("FAIL w1_cin0: got %0b expected 0", b_q); end
    b_mode = 2'b10;
    tick();
    checks++; if (b_q !== 1'b1) begin errors++; $display("FAIL w1_dn1: got %0b expected 1", b_q); end
    tick();
    checks++; if (b_q !== 1'b0) begin errors++; $display("FAIL w1_dn0: got %0b expected 0", b_q); end
  endtask

  initial begin
    test_reset();
    test_up_wrap();
    test_down_wrap();
    test_set_clear();
    test_hold_priority();
    test_back_to_back();
    test_cascade();
    test_width1();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
